// File: rtl/qupls_rat_backout_sink.sv
// qupls_rat_backout_sink
// Architectural-to-physical register map that takes restore writes from the
// branch-mispredict backout machine and normal rename writes. Backout always
// wins a same-cycle collision. Physical registers discarded by a restore are
// queued in a small valid/ready FIFO for return to the free list.
module qupls_rat_backout_sink #(
   parameter int AREGS  = 64,
   parameter int PREGS  = 512,
   parameter int FDEPTH = 4,
   localparam int AW    = $clog2(AREGS),
   localparam int PW    = $clog2(PREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bo_wr,
   input  logic [AW-1:0] bo_areg,
   input  logic [PW-1:0] bo_preg,
   input  logic [PW-1:0] bo_nreg,
   input  logic          rn_wr,
   input  logic [AW-1:0] rn_areg,
   input  logic [PW-1:0] rn_preg,
   input  logic [AW-1:0] rd_areg0,
   input  logic [AW-1:0] rd_areg1,
   output logic [PW-1:0] rd_preg0,
   output logic [PW-1:0] rd_preg1,
   output logic          fr_valid,
   output logic [PW-1:0] fr_preg,
   input  logic          fr_ready,
   output logic          fifo_full,
   input  logic          bo_clr,
   output logic [7:0]    bo_count,
   output logic          ovf,
   output logic          conflict
);

   localparam int FW = $clog2(FDEPTH);

   logic [PW-1:0] map [AREGS];

   logic [PW-1:0] fifo_mem [FDEPTH];
   logic [FW:0]   wr_ptr;
   logic [FW:0]   rd_ptr;

   logic fifo_empty;
   logic push_req;
   logic pop;
   logic push_ok;
   logic push_drop;

   // Map reads are straight from the table; a same-cycle write is not bypassed.
   assign rd_preg0 = map[rd_areg0];
   assign rd_preg1 = map[rd_areg1];

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
   assign fr_valid   = !fifo_empty;
   assign fr_preg    = fifo_empty ? '0 : fifo_mem[rd_ptr[FW-1:0]];

   // Preg 0 means "none", so only a real discarded mapping is returned.
   assign push_req  = bo_wr && (bo_nreg != '0);
   assign pop       = fr_valid && fr_ready;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign push_ok   = push_req && (!fifo_full || pop);
   assign push_drop = push_req && fifo_full && !pop;

   // Map table: identity on reset, backout write has priority over rename.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < AREGS; i++)
            map[i] <= PW'(i);
      end else if (bo_wr) begin
         map[bo_areg] <= bo_preg;
      end else if (rn_wr) begin
         map[rn_areg] <= rn_preg;
      end
   end

   // FIFO storage; contents are qualified by the pointers so need no reset.
   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr[FW-1:0]] <= bo_nreg;
   end

   // FIFO pointers; reset discards any entries still pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Saturating restore counter and sticky flags; clear beats any set.
   always_ff @(posedge clk) begin
      if (rst) begin
         bo_count <= '0;
         ovf      <= 1'b0;
         conflict <= 1'b0;
      end else if (bo_clr) begin
         bo_count <= '0;
         ovf      <= 1'b0;
         conflict <= 1'b0;
      end else begin
         if (bo_wr && (bo_count != 8'hFF))
            bo_count <= bo_count + 8'd1;
         if (push_drop)
            ovf <= 1'b1;
         if (bo_wr && rn_wr)
            conflict <= 1'b1;
      end
   end

endmodule

// File: tb/tb_qupls_rat_backout_sink.sv
// Directed bench for qupls_rat_backout_sink with hand-computed expectations.
module tb_qupls_rat_backout_sink;

   localparam int AW = 6;
   localparam int PW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          bo_wr;
   logic [AW-1:0] bo_areg;
   logic [PW-1:0] bo_preg;
   logic [PW-1:0] bo_nreg;
   logic          rn_wr;
   logic [AW-1:0] rn_areg;
   logic [PW-1:0] rn_preg;
   logic [AW-1:0] rd_areg0;
   logic [AW-1:0] rd_areg1;
   logic [PW-1:0] rd_preg0;
   logic [PW-1:0] rd_preg1;
   logic          fr_valid;
   logic [PW-1:0] fr_preg;
   logic          fr_ready;
   logic          fifo_full;
   logic          bo_clr;
   logic [7:0]    bo_count;
   logic          ovf;
   logic          conflict;

   int n_vec = 0;
   int n_err = 0;

   qupls_rat_backout_sink dut (
      .clk(clk), .rst(rst),
      .bo_wr(bo_wr), .bo_areg(bo_areg), .bo_preg(bo_preg), .bo_nreg(bo_nreg),
      .rn_wr(rn_wr), .rn_areg(rn_areg), .rn_preg(rn_preg),
      .rd_areg0(rd_areg0), .rd_areg1(rd_areg1),
      .rd_preg0(rd_preg0), .rd_preg1(rd_preg1),
      .fr_valid(fr_valid), .fr_preg(fr_preg), .fr_ready(fr_ready),
      .fifo_full(fifo_full), .bo_clr(bo_clr), .bo_count(bo_count),
      .ovf(ovf), .conflict(conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bo_wr = 1'b0; bo_areg = '0; bo_preg = '0; bo_nreg = '0;
      rn_wr = 1'b0; rn_areg = '0; rn_preg = '0;
      bo_clr = 1'b0;
   endtask

   task automatic restore(input int a, input int p, input int n);
      bo_wr = 1'b1; bo_areg = AW'(a); bo_preg = PW'(p); bo_nreg = PW'(n);
      tick();
      idle();
   endtask

   task automatic read_map(input int a, input int exp, input string tag);
      rd_areg0 = AW'(a);
      #1;
      chk(tag, rd_preg0, exp);
   endtask

   initial begin
      idle();
      fr_ready = 1'b0;
      rd_areg0 = '0;
      rd_areg1 = '0;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      rd_areg0 = 6'd5;
      rd_areg1 = 6'd63;
      #1;
      chk("rst_rd0", rd_preg0, 5);
      chk("rst_rd1", rd_preg1, 63);
      chk("rst_fr_valid", fr_valid, 0);
      chk("rst_fr_preg", fr_preg, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_count", bo_count, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_conflict", conflict, 0);

      // Basic restore
      rn_wr = 1'b1; rn_areg = 6'd7; rn_preg = 9'd100;
      tick();
      idle();
      read_map(7, 100, "rn_map7");
      bo_wr = 1'b1; bo_areg = 6'd7; bo_preg = 9'd7; bo_nreg = 9'd100;
      #1;
      chk("no_bypass_map7", rd_preg0, 100);
      tick();
      idle();
      read_map(7, 7, "bo_map7");
      chk("bo_fr_valid", fr_valid, 1);
      chk("bo_fr_preg", fr_preg, 100);
      chk("bo_count1", bo_count, 1);
      fr_ready = 1'b1;
      tick();
      fr_ready = 1'b0;
      chk("bo_drained", fr_valid, 0);

      // Burst of five with consumer stalled
      for (int k = 0; k < 5; k++) begin
         restore(10 + k, 10 + k, 10 + k);
         chk("burst_full", fifo_full, (k >= 3) ? 1 : 0);
         chk("burst_ovf", ovf, (k == 4) ? 1 : 0);
      end
      chk("burst_count", bo_count, 6);
      fr_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk("burst_valid", fr_valid, 1);
         chk("burst_order", fr_preg, 10 + j);
         tick();
      end
      chk("burst_empty", fr_valid, 0);
      fr_ready = 1'b0;

      // Clear
      bo_clr = 1'b1;
      tick();
      idle();
      chk("clr_ovf", ovf, 0);
      chk("clr_count", bo_count, 0);

      // Full + push + pop in one cycle
      for (int k = 0; k < 4; k++)
         restore(20 + k, 20 + k, 20 + k);
      chk("fpp_full", fifo_full, 1);
      fr_ready = 1'b1;
      restore(24, 24, 24);
      chk("fpp_ovf", ovf, 0);
      chk("fpp_full_after", fifo_full, 1);
      for (int j = 0; j < 4; j++) begin
         chk("fpp_order", fr_preg, 21 + j);
         tick();
      end
      chk("fpp_empty", fr_valid, 0);
      fr_ready = 1'b0;
      chk("fpp_count", bo_count, 5);

      // Conflict: backout wins even on a different areg
      bo_wr = 1'b1; bo_areg = 6'd3; bo_preg = 9'd3; bo_nreg = 9'd0;
      rn_wr = 1'b1; rn_areg = 6'd4; rn_preg = 9'd200;
      tick();
      idle();
      read_map(3, 3, "cf_map3");
      read_map(4, 4, "cf_map4");
      chk("cf_flag", conflict, 1);
      chk("cf_count", bo_count, 6);
      chk("cf_no_push", fr_valid, 0);
      bo_clr = 1'b1;
      tick();
      idle();
      chk("cf_clr_flag", conflict, 0);
      chk("cf_clr_count", bo_count, 0);

      // Clear beats increment in the same cycle
      bo_clr = 1'b1;
      restore(0, 0, 0);
      chk("clr_prio_count", bo_count, 0);

      // Saturation at 255
      for (int k = 0; k < 254; k++)
         restore(0, 0, 0);
      chk("sat_254", bo_count, 254);
      for (int k = 0; k < 6; k++)
         restore(0, 0, 0);
      chk("sat_255", bo_count, 255);
      bo_clr = 1'b1;
      tick();
      idle();

      // Zero nreg then reset mid-stream
      restore(9, 300, 0);
      chk("z_no_push", fr_valid, 0);
      chk("z_count", bo_count, 1);
      read_map(9, 300, "z_map9");
      restore(9, 301, 50);
      restore(9, 302, 51);
      chk("z_valid", fr_valid, 1);
      chk("z_head", fr_preg, 50);
      chk("z_count3", bo_count, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("z_rst_valid", fr_valid, 0);
      chk("z_rst_full", fifo_full, 0);
      chk("z_rst_count", bo_count, 0);
      read_map(9, 9, "z_rst_map9");
      read_map(7, 7, "z_rst_map7");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
